axis_segment_sequencer: RTL and testbench

- Controller that sequences the segmented BRAM reader through a programmable list of BRAM address segments.
- For each segment it drives the reader's start offset and end address, holds the reader in reset to load them, then waits for the reader's end-of-segment config handshake.
- Segments can repeat individually, and the whole list can loop.
- Sits between the PS-side configuration registers and one segmented BRAM reader instance.

---
 rtl/axis_seq_pkg.sv | 25 ++
 rtl/segment_table.sv | 36 +++
 rtl/axis_segment_sequencer.sv | 175 +++++++++++++++++
 tb/tb_axis_segment_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_seq_pkg.sv
// Shared types and default widths for the segment sequencer and its table.
// No logic; latency and backpressure are defined by the modules that import it.
package axis_seq_pkg;

    localparam int BRAM_ADDR_WIDTH_DEF = 10;
    localparam int SEG_IDX_WIDTH_DEF   = 4;
    localparam int RPT_WIDTH_DEF       = 8;
    localparam int ARM_CYCLES_DEF      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_ARM,
        ST_RUN,
        ST_NEXT_SEG
    } seq_state_e;

    typedef struct packed {
        logic [BRAM_ADDR_WIDTH_DEF-1:0] start_addr;
        logic [BRAM_ADDR_WIDTH_DEF-1:0] end_addr;
        logic [RPT_WIDTH_DEF-1:0]       rpt;
    } seg_entry_t;

endpackage

// File: rtl/segment_table.sv
// Segment table: 2^IDX_W entries, one registered write port, one registered read port.
// Writes land one cycle after the strobe; read data appears the cycle after rd_idx; no backpressure.
module segment_table
    import axis_seq_pkg::*;
#(
    parameter int  IDX_W   = SEG_IDX_WIDTH_DEF,
    parameter type entry_t = seg_entry_t
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  entry_t           wr_dat,
    input  logic [IDX_W-1:0] rd_idx,
    output entry_t           rd_dat
);

    entry_t           mem [2**IDX_W];
    logic             wr_vld_q;
    logic [IDX_W-1:0] wr_idx_q;
    entry_t           wr_dat_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) wr_vld_q <= 1'b0;
        else          wr_vld_q <= wr_en;
    end

    // Storage is deliberately left unreset so it maps onto plain RAM.
    always_ff @(posedge aclk) begin
        wr_idx_q <= wr_idx;
        wr_dat_q <= wr_dat;
        if (wr_vld_q) mem[wr_idx_q] <= wr_dat_q;
        rd_dat <= mem[rd_idx];
    end

endmodule

// File: rtl/axis_segment_sequencer.sv
// Walks a segment table, arming the BRAM reader with offset/end per segment, with repeats and looping.
// start->reader released after 3+ARM_CYCLES cycles; waits indefinitely on the reader's done handshake.
module axis_segment_sequencer
    import axis_seq_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = BRAM_ADDR_WIDTH_DEF,
    parameter int SEG_IDX_WIDTH   = SEG_IDX_WIDTH_DEF,
    parameter int RPT_WIDTH       = RPT_WIDTH_DEF,
    parameter int ARM_CYCLES      = ARM_CYCLES_DEF
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       tbl_wr_en,
    input  logic [SEG_IDX_WIDTH-1:0]   tbl_wr_idx,
    input  logic [BRAM_ADDR_WIDTH-1:0] tbl_wr_start,
    input  logic [BRAM_ADDR_WIDTH-1:0] tbl_wr_end,
    input  logic [RPT_WIDTH-1:0]       tbl_wr_rpt,
    input  logic [SEG_IDX_WIDTH:0]     num_segments,
    input  logic                       loop_en,
    input  logic                       start,
    input  logic                       abort,
    output logic                       rdr_aresetn,
    output logic [BRAM_ADDR_WIDTH-1:0] rdr_offset,
    output logic [BRAM_ADDR_WIDTH-1:0] rdr_end,
    input  logic                       rdr_done_tvalid,
    output logic                       rdr_done_tready,
    output logic                       busy,
    output logic [SEG_IDX_WIDTH-1:0]   cur_seg,
    output logic                       done,
    output logic                       err
);

    typedef struct packed {
        logic [BRAM_ADDR_WIDTH-1:0] start_addr;
        logic [BRAM_ADDR_WIDTH-1:0] end_addr;
        logic [RPT_WIDTH-1:0]       rpt;
    } entry_t;

    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [ARM_W-1:0]       ARM_LAST = ARM_W'(ARM_CYCLES - 1);
    localparam logic [SEG_IDX_WIDTH:0] MAX_SEGS = {1'b1, {SEG_IDX_WIDTH{1'b0}}};

    seq_state_e                 state_q, state_d;
    logic [SEG_IDX_WIDTH-1:0]   seg_q, seg_d;
    logic [RPT_WIDTH-1:0]       rpt_q, rpt_d;
    logic [ARM_W-1:0]           arm_q, arm_d;
    logic [BRAM_ADDR_WIDTH-1:0] off_q, off_d;
    logic [BRAM_ADDR_WIDTH-1:0] end_q, end_d;
    logic                       err_q, err_d;
    logic                       done_q, done_d;
    logic [SEG_IDX_WIDTH:0]     seg_nxt;
    entry_t                     wr_entry;
    entry_t                     rd_entry;

    assign wr_entry = '{start_addr: tbl_wr_start, end_addr: tbl_wr_end, rpt: tbl_wr_rpt};
    assign seg_nxt  = {1'b0, seg_q} + (SEG_IDX_WIDTH+1)'(1);

    // Read address follows seg_d so the entry is already valid during LOAD.
    segment_table #(
        .IDX_W   (SEG_IDX_WIDTH),
        .entry_t (entry_t)
    ) u_table (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_en   (tbl_wr_en && (state_q == ST_IDLE)),
        .wr_idx  (tbl_wr_idx),
        .wr_dat  (wr_entry),
        .rd_idx  (seg_d),
        .rd_dat  (rd_entry)
    );

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        rpt_d   = rpt_q;
        arm_d   = arm_q;
        off_d   = off_q;
        end_d   = end_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (tbl_wr_en && (state_q != ST_IDLE)) err_d = 1'b1;
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if ((num_segments == '0) || (num_segments > MAX_SEGS)) begin
                            err_d = 1'b1;
                        end else begin
                            err_d   = 1'b0;
                            seg_d   = '0;
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    off_d   = rd_entry.start_addr;
                    end_d   = rd_entry.end_addr;
                    rpt_d   = rd_entry.rpt;
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (end_q <= off_q) begin
                        err_d   = 1'b1;
                        state_d = ST_NEXT_SEG;
                    end else begin
                        arm_d   = '0;
                        state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (arm_q == ARM_LAST) state_d = ST_RUN;
                    else                   arm_d   = arm_q + ARM_W'(1);
                end
                ST_RUN: begin
                    if (rdr_done_tvalid) begin
                        if (rpt_q != '0) begin
                            rpt_d   = rpt_q - RPT_WIDTH'(1);
                            arm_d   = '0;
                            state_d = ST_ARM;
                        end else begin
                            state_d = ST_NEXT_SEG;
                        end
                    end
                end
                ST_NEXT_SEG: begin
                    if (seg_nxt < num_segments) begin
                        seg_d   = seg_nxt[SEG_IDX_WIDTH-1:0];
                        state_d = ST_LOAD;
                    end else if (loop_en) begin
                        seg_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            seg_q   <= '0;
            rpt_q   <= '0;
            arm_q   <= '0;
            off_q   <= '0;
            end_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            rpt_q   <= rpt_d;
            arm_q   <= arm_d;
            off_q   <= off_d;
            end_q   <= end_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign rdr_aresetn     = (state_q == ST_RUN);
    assign rdr_done_tready = (state_q == ST_RUN);
    assign busy            = (state_q != ST_IDLE);
    assign rdr_offset      = off_q;
    assign rdr_end         = end_q;
    assign cur_seg         = seg_q;
    assign done            = done_q;
    assign err             = err_q;

endmodule

// File: tb/tb_axis_segment_sequencer.sv
// Scoreboarded bench for axis_segment_sequencer with a behavioural reader model.
// Expected reader arms are queued at start and popped on each reader release.
module tb_axis_segment_sequencer;

    logic       aclk;
    logic       aresetn;
    logic       tbl_wr_en;
    logic [3:0] tbl_wr_idx;
    logic [9:0] tbl_wr_start;
    logic [9:0] tbl_wr_end;
    logic [7:0] tbl_wr_rpt;
    logic [4:0] num_segments;
    logic       loop_en;
    logic       start;
    logic       abort;
    logic       rdr_aresetn;
    logic [9:0] rdr_offset;
    logic [9:0] rdr_end;
    logic       rdr_done_tvalid;
    logic       rdr_done_tready;
    logic       busy;
    logic [3:0] cur_seg;
    logic       done;
    logic       err;

    logic model_en;
    logic model_tvalid;
    logic force_tvalid;
    logic prev_arn;
    int   beat;
    int   n_tests;
    int   n_fail;
    int   runs_seen;
    int   done_cnt;

    typedef struct {
        int off;
        int e;
        int idx;
    } exp_t;
    exp_t exp_q[$];

    assign rdr_done_tvalid = model_tvalid | force_tvalid;

    axis_segment_sequencer dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .tbl_wr_en       (tbl_wr_en),
        .tbl_wr_idx      (tbl_wr_idx),
        .tbl_wr_start    (tbl_wr_start),
        .tbl_wr_end      (tbl_wr_end),
        .tbl_wr_rpt      (tbl_wr_rpt),
        .num_segments    (num_segments),
        .loop_en         (loop_en),
        .start           (start),
        .abort           (abort),
        .rdr_aresetn     (rdr_aresetn),
        .rdr_offset      (rdr_offset),
        .rdr_end         (rdr_end),
        .rdr_done_tvalid (rdr_done_tvalid),
        .rdr_done_tready (rdr_done_tready),
        .busy            (busy),
        .cur_seg         (cur_seg),
        .done            (done),
        .err             (err)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reader model: asserts done after end-start+1 beats of being out of reset.
    always @(negedge aclk) begin
        if (!rdr_aresetn || !model_en) begin
            beat         = 0;
            model_tvalid = 1'b0;
        end else if (!model_tvalid) begin
            beat++;
            if (beat == int'(rdr_end) - int'(rdr_offset) + 1) model_tvalid = 1'b1;
        end
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            if (rdr_aresetn && !prev_arn) begin
                exp_t e;
                runs_seen++;
                if (exp_q.size() == 0) begin
                    check("sb_expected_arm_available", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("arm_offset", rdr_offset, e.off);
                    check("arm_end", rdr_end, e.e);
                    check("arm_seg", cur_seg, e.idx);
                end
            end
            if (done) done_cnt++;
        end
        prev_arn = rdr_aresetn;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int off, input int e, input int idx);
        exp_t x;
        x.off = off; x.e = e; x.idx = idx;
        exp_q.push_back(x);
    endtask

    task automatic write_entry(input int idx, input int s, input int e, input int r);
        @(negedge aclk);
        tbl_wr_en    = 1'b1;
        tbl_wr_idx   = 4'(idx);
        tbl_wr_start = 10'(s);
        tbl_wr_end   = 10'(e);
        tbl_wr_rpt   = 8'(r);
        @(negedge aclk);
        tbl_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        repeat (2) @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge aclk);
            if (done) seen = 1'b1;
        end
        check(tag, 32'(seen), 1);
    endtask

    initial begin
        int d0;
        int r0;
        bit hit;
        n_tests = 0; n_fail = 0; runs_seen = 0; done_cnt = 0;
        prev_arn = 1'b0; beat = 0; model_tvalid = 1'b0;
        model_en = 1'b1; force_tvalid = 1'b0;
        aresetn = 1'b0; tbl_wr_en = 1'b0; tbl_wr_idx = '0;
        tbl_wr_start = '0; tbl_wr_end = '0; tbl_wr_rpt = '0;
        num_segments = 5'd1; loop_en = 1'b0; start = 1'b0; abort = 1'b0;

        #12;
        check("rst_rdr_aresetn", rdr_aresetn, 0);
        check("rst_offset", rdr_offset, 0);
        check("rst_end", rdr_end, 0);
        check("rst_tready", rdr_done_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_seg", cur_seg, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Two segments, second one repeated once.
        write_entry(0, 0, 9, 0);
        write_entry(1, 16, 31, 1);
        num_segments = 5'd2;
        push_exp(0, 9, 0); push_exp(16, 31, 1); push_exp(16, 31, 1);
        d0 = done_cnt;
        pulse_start();
        wait_done("two_seg_done", 300);
        check("two_seg_busy_low", busy, 0);
        check("two_seg_err", err, 0);
        repeat (3) @(negedge aclk);
        check("two_seg_done_pulses", done_cnt - d0, 1);
        check("two_seg_sb_empty", exp_q.size(), 0);

        // Arm timing relative to the sampled start edge.
        write_entry(0, 5, 12, 0);
        num_segments = 5'd1;
        push_exp(5, 12, 0);
        repeat (2) @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge aclk);
            check($sformatf("arm_rdr_aresetn_c%0d", k), rdr_aresetn, (k <= 4) ? 0 : 1);
            check($sformatf("arm_tready_c%0d", k), rdr_done_tready, (k <= 4) ? 0 : 1);
            if (k >= 2) check($sformatf("arm_offset_c%0d", k), rdr_offset, 5);
        end
        wait_done("arm_done", 200);

        // Loop twice through three segments, dropping loop_en in the second pass.
        write_entry(0, 0, 3, 0);
        write_entry(1, 8, 11, 0);
        write_entry(2, 16, 19, 0);
        num_segments = 5'd3;
        loop_en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            push_exp(0, 3, 0); push_exp(8, 11, 1); push_exp(16, 19, 2);
        end
        d0 = done_cnt;
        r0 = runs_seen;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge aclk);
            if (runs_seen >= r0 + 4) hit = 1'b1;
        end
        check("loop_second_pass_reached", 32'(hit), 1);
        loop_en = 1'b0;
        wait_done("loop_done", 300);
        repeat (3) @(negedge aclk);
        check("loop_done_pulses", done_cnt - d0, 1);
        check("loop_sb_empty", exp_q.size(), 0);

        // Zero-length middle entry is skipped and flags err.
        write_entry(1, 20, 20, 0);
        push_exp(0, 3, 0); push_exp(16, 19, 2);
        d0 = done_cnt;
        pulse_start();
        wait_done("skip_done", 300);
        check("skip_err", err, 1);
        repeat (3) @(negedge aclk);
        check("skip_done_pulses", done_cnt - d0, 1);
        check("skip_sb_empty", exp_q.size(), 0);

        // Abort in RUN coinciding with the reader's done handshake.
        num_segments = 5'd1;
        model_en = 1'b0;
        push_exp(0, 3, 0);
        pulse_start();
        check("abort_start_cleared_err", err, 0);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (rdr_done_tready) hit = 1'b1;
            else @(negedge aclk);
        end
        check("abort_reached_run", 32'(hit), 1);
        d0 = done_cnt;
        abort = 1'b1;
        force_tvalid = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        force_tvalid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_rdr_aresetn", rdr_aresetn, 0);
        check("abort_tready", rdr_done_tready, 0);
        check("abort_err_kept", err, 0);
        repeat (4) @(negedge aclk);
        check("abort_no_done", done_cnt - d0, 0);
        model_en = 1'b1;
        push_exp(0, 3, 0);
        pulse_start();
        wait_done("abort_restart_done", 200);
        check("abort_sb_empty", exp_q.size(), 0);

        // Table write while busy is dropped and flags err.
        write_entry(0, 0, 9, 0);
        push_exp(0, 9, 0);
        pulse_start();
        write_entry(0, 100, 200, 0);
        check("busy_write_err", err, 1);
        wait_done("busy_write_done", 200);
        push_exp(0, 9, 0);
        pulse_start();
        check("restart_clears_err", err, 0);
        wait_done("busy_write_rerun_done", 200);
        check("busy_write_sb_empty", exp_q.size(), 0);

        // Start with no segments programmed.
        num_segments = 5'd0;
        pulse_start();
        check("bad_start_err", err, 1);
        check("bad_start_busy", busy, 0);
        @(negedge aclk);
        check("bad_start_stay_idle", busy, 0);
        num_segments = 5'd17;
        pulse_start();
        check("oversize_start_busy", busy, 0);
        check("oversize_start_err", err, 1);

        repeat (4) @(negedge aclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
